bonus_ship_scheduler: RTL

BONUS_SHIP_SCHEDULER -- requirements
Module: bonus_ship_scheduler

---
 rtl/bonus_pkg.sv | 33 +++
 rtl/frame_down_counter.sv | 43 ++++
 rtl/bonus_ship_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bonus_pkg.sv
// -----------------------------------------------------------------------------
// bonus_pkg
// Shared definitions for the bonus-ship scheduler: FSM state encoding,
// counter widths and the hit-score table.
// Ports: none (package).
// -----------------------------------------------------------------------------
package bonus_pkg;

    localparam int DELAY_W = 11;   // MIN_DELAY_FRAMES + 10-bit random delay
    localparam int RND_W   = 10;
    localparam int SHOT_W  = 4;
    localparam int SCORE_W = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        FLY     = 2'd2,
        EXPLODE = 2'd3
    } bonusStateT;

    // Points for a hit, selected by the low two bits of the shot count.
    function automatic logic [SCORE_W-1:0] scoreForShots(input logic [1:0] idx);
        logic [SCORE_W-1:0] pts;
        case (idx)
            2'd0:    pts = 9'd50;
            2'd1:    pts = 9'd100;
            2'd2:    pts = 9'd150;
            default: pts = 9'd300;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/frame_down_counter.sv
// -----------------------------------------------------------------------------
// frame_down_counter
// Frame-based down-counter used for both the launch delay and the explosion
// duration. Load has priority over counting, so a startOfFrame that lands on
// the load cycle is not counted.
// Ports:
//   clk, resetN      clock, async active-low reset
//   clear            synchronous clear to 0 (highest priority)
//   load, loadValue  load a new frame count
//   startOfFrame     decrement by one (stops at 0)
//   reachedOne       high while the count equals 1
// -----------------------------------------------------------------------------
module frame_down_counter
    import bonus_pkg::*;
#(
    parameter int W = DELAY_W
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    input  logic         startOfFrame,
    output logic         reachedOne
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (startOfFrame && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign reachedOne = (count == W'(1));

endmodule

// File: rtl/bonus_ship_scheduler.sv
// -----------------------------------------------------------------------------
// bonus_ship_scheduler
// Schedules bonus-ship passes: waits a minimum plus random number of frames,
// launches the ship, scores a hit from the shot count, shows the explosion,
// then waits again. Dropping playGame returns to IDLE from any state.
// Ports:
//   clk, resetN         clock, async active-low reset
//   startOfFrame        one-cycle pulse per frame
//   playGame            level, game in progress
//   rndDelay[9:0]       extra random delay, sampled on delay load
//   playerShot          one-cycle pulse per shot fired
//   bonusFireCollision  shot hit the bonus ship
//   shipExited          ship left the screen unhit
//   launch              one-cycle pulse starting a pass
//   bonusActive         ship flying
//   exploding           explosion displayed
//   scoreValid          one-cycle pulse on a hit
//   scoreValue[8:0]     points of the last hit
//
// state   | meaning
// IDLE    | no game; counters idle
// WAIT    | counting frames until next launch
// FLY     | ship on screen
// EXPLODE | explosion shown for EXPLODE_FRAMES frames
// -----------------------------------------------------------------------------
module bonus_ship_scheduler
    import bonus_pkg::*;
#(
    parameter int MIN_DELAY_FRAMES = 300,
    parameter int EXPLODE_FRAMES   = 30
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               playGame,
    input  logic [RND_W-1:0]   rndDelay,
    input  logic               playerShot,
    input  logic               bonusFireCollision,
    input  logic               shipExited,
    output logic               launch,
    output logic               bonusActive,
    output logic               exploding,
    output logic               scoreValid,
    output logic [SCORE_W-1:0] scoreValue
);

    bonusStateT          state;
    logic [SHOT_W-1:0]   shotCnt;
    logic                ctrClear;
    logic                ctrLoad;
    logic [DELAY_W-1:0]  ctrLoadValue;
    logic                ctrTick;
    logic                ctrOne;
    logic [DELAY_W-1:0]  waitDelay;

    assign waitDelay = DELAY_W'(MIN_DELAY_FRAMES) + DELAY_W'(rndDelay);

    // One counter serves WAIT and EXPLODE; every entry into either reloads it.
    always_comb begin
        ctrClear     = !playGame;
        ctrLoad      = 1'b0;
        ctrLoadValue = waitDelay;
        ctrTick      = startOfFrame && ((state == WAIT) || (state == EXPLODE));
        if (playGame) begin
            case (state)
                IDLE: ctrLoad = 1'b1;
                FLY: begin
                    if (bonusFireCollision) begin
                        ctrLoad      = 1'b1;
                        ctrLoadValue = DELAY_W'(EXPLODE_FRAMES);
                    end else if (shipExited) begin
                        ctrLoad = 1'b1;
                    end
                end
                EXPLODE: ctrLoad = startOfFrame && ctrOne;
                default: ;
            endcase
        end
    end

    frame_down_counter #(.W(DELAY_W)) uFrameCounter (
        .clk         (clk),
        .resetN      (resetN),
        .clear       (ctrClear),
        .load        (ctrLoad),
        .loadValue   (ctrLoadValue),
        .startOfFrame(ctrTick),
        .reachedOne  (ctrOne)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            shotCnt     <= '0;
            launch      <= 1'b0;
            bonusActive <= 1'b0;
            exploding   <= 1'b0;
            scoreValid  <= 1'b0;
            scoreValue  <= '0;
        end else begin
            launch     <= 1'b0;
            scoreValid <= 1'b0;

            if (playGame) begin
                if (state == IDLE) begin
                    shotCnt <= '0;
                end else if (playerShot) begin
                    shotCnt <= shotCnt + SHOT_W'(1);
                end
            end

            if (!playGame) begin
                state       <= IDLE;
                bonusActive <= 1'b0;
                exploding   <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= WAIT;
                    WAIT: begin
                        if (startOfFrame && ctrOne) begin
                            state       <= FLY;
                            launch      <= 1'b1;
                            bonusActive <= 1'b1;
                        end
                    end
                    FLY: begin
                        if (bonusFireCollision) begin
                            // Registered shotCnt is the pre-increment value.
                            state       <= EXPLODE;
                            bonusActive <= 1'b0;
                            exploding   <= 1'b1;
                            scoreValid  <= 1'b1;
                            scoreValue  <= scoreForShots(shotCnt[1:0]);
                        end else if (shipExited) begin
                            state       <= WAIT;
                            bonusActive <= 1'b0;
                        end
                    end
                    EXPLODE: begin
                        if (startOfFrame && ctrOne) begin
                            state     <= WAIT;
                            exploding <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
